// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM state type and
// default parameter values.
package perf_pkg;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StHalted = 1'b1
    } state_e;

    localparam int unsigned DefNumCh  = 4;
    localparam int unsigned DefCntW   = 16;
    localparam int unsigned DefDispW  = 32;
    localparam int unsigned DefSat    = 0;

endpackage

// File: rtl/perf_counter_slice.sv
// Single event counter with wrap or saturate behaviour and a sticky overflow flag.
module perf_counter_slice
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW,
    parameter int unsigned SAT   = DefSat
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;
    logic             at_max;

    assign at_max = (cnt == {CNT_W{1'b1}});

    always_comb begin
        cnt_d = cnt;
        ovf_d = ovf;
        if (inc) begin
            if (at_max) begin
                ovf_d = 1'b1;
                // Saturating mode leaves the counter pinned at its maximum.
                if (SAT == 0) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_d;
            ovf <= ovf_d;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with run/halt control, snapshot shadow registers and a
// registered readout mux for the seven-segment display path.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH  = DefNumCh,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned DISP_W  = DefDispW,
    parameter int unsigned SAT     = DefSat,
    localparam int unsigned SelW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              halt,
    input  logic [NUM_CH-1:0] ev,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic              snap,
    input  logic              live,
    input  logic [SelW-1:0]   sel,
    output logic [DISP_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] ovf,
    output logic              running
);

    state_e            state_q;
    logic [NUM_CH-1:0] inc;
    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  rd_sel;
    logic [DISP_W-1:0] rd_ext;

    // An event in the cycle halt is first seen still counts: state is RUN then.
    assign inc = (state_q == StRun && !clr) ? (ev & en_mask) : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
        perf_counter_slice #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_slice (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc[g]),
            .cnt (cnt[g]),
            .ovf (ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            state_q <= StRun;
            running <= 1'b1;
        end else if (state_q == StRun && halt) begin
            state_q <= StHalted;
            running <= 1'b0;
        end
    end

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (SelW'(i) == sel) begin
                rd_sel = live ? cnt[i] : shadow_q[i];
            end
        end
    end

    always_comb begin
        rd_ext              = '0;
        rd_ext[CNT_W-1:0]   = rd_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (snap) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    shadow_q[i] <= cnt[i];
                end
                rd_valid <= 1'b1;
            end
            rd_data <= rd_ext;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: default, 4-bit wrapping and 4-bit
// saturating (5-channel) instances share one stimulus stream.
module tb_perf_counter_bank;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        halt;
    logic        snap;
    logic        live;
    logic [4:0]  ev;
    logic [4:0]  en_mask;
    logic [2:0]  sel;

    logic [31:0] d_rd;
    logic        d_valid;
    logic [3:0]  d_ovf;
    logic        d_run;
    logic [31:0] w_rd;
    logic        w_valid;
    logic [3:0]  w_ovf;
    logic        w_run;
    logic [31:0] s_rd;
    logic        s_valid;
    logic [4:0]  s_ovf;
    logic        s_run;

    int n_cmp = 0;
    int n_err = 0;

    perf_counter_bank u_dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .halt     (halt),
        .ev       (ev[3:0]),
        .en_mask  (en_mask[3:0]),
        .snap     (snap),
        .live     (live),
        .sel      (sel[1:0]),
        .rd_data  (d_rd),
        .rd_valid (d_valid),
        .ovf      (d_ovf),
        .running  (d_run)
    );

    perf_counter_bank #(
        .NUM_CH (4),
        .CNT_W  (4),
        .DISP_W (32),
        .SAT    (0)
    ) u_wrap (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .halt     (halt),
        .ev       (ev[3:0]),
        .en_mask  (en_mask[3:0]),
        .snap     (snap),
        .live     (live),
        .sel      (sel[1:0]),
        .rd_data  (w_rd),
        .rd_valid (w_valid),
        .ovf      (w_ovf),
        .running  (w_run)
    );

    perf_counter_bank #(
        .NUM_CH (5),
        .CNT_W  (4),
        .DISP_W (32),
        .SAT    (1)
    ) u_sat (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .halt     (halt),
        .ev       (ev),
        .en_mask  (en_mask),
        .snap     (snap),
        .live     (live),
        .sel      (sel),
        .rd_data  (s_rd),
        .rd_valid (s_valid),
        .ovf      (s_ovf),
        .running  (s_run)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL reset_rd: got %0d expected 0", d_rd); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0d expected 0", d_valid); end
        n_cmp++; if (d_ovf !== 4'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0000", d_ovf); end
        n_cmp++; if (d_run !== 1'b1) begin n_err++; $display("FAIL reset_running: got %0d expected 1", d_run); end
        n_cmp++; if (s_run !== 1'b1) begin n_err++; $display("FAIL reset_running_sat: got %0d expected 1", s_run); end
        rst = 1'b1;
    endtask

    task automatic test_count_snap();
        ev = 5'b01111;
        repeat (10) tick();
        ev   = 5'b0;
        snap = 1'b1;
        sel  = 3'd2;
        live = 1'b0;
        tick();
        snap = 1'b0;
        tick();
        n_cmp++; if (d_rd !== 32'd10) begin n_err++; $display("FAIL snap_shadow_ch2: got %0d expected 10", d_rd); end
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL snap_valid: got %0d expected 1", d_valid); end
        n_cmp++; if (w_rd !== 32'd10) begin n_err++; $display("FAIL snap_shadow_wrap: got %0d expected 10", w_rd); end
        live = 1'b1;
        tick();
        n_cmp++; if (d_rd !== 32'd10) begin n_err++; $display("FAIL live_ch2: got %0d expected 10", d_rd); end
        // Snapshot in a counting cycle captures the pre-increment value.
        ev   = 5'b00001;
        snap = 1'b1;
        sel  = 3'd0;
        live = 1'b0;
        tick();
        ev   = 5'b0;
        snap = 1'b0;
        tick();
        n_cmp++; if (d_rd !== 32'd10) begin n_err++; $display("FAIL snap_pre_inc: got %0d expected 10", d_rd); end
        live = 1'b1;
        tick();
        n_cmp++; if (d_rd !== 32'd11) begin n_err++; $display("FAIL live_post_inc: got %0d expected 11", d_rd); end
        en_mask = 5'b00101;
        ev      = 5'b01111;
        repeat (3) tick();
        en_mask = 5'b11111;
        ev      = 5'b0;
        sel     = 3'd1;
        tick();
        n_cmp++; if (d_rd !== 32'd10) begin n_err++; $display("FAIL mask_ch1: got %0d expected 10", d_rd); end
        sel = 3'd2;
        tick();
        n_cmp++; if (d_rd !== 32'd13) begin n_err++; $display("FAIL mask_ch2: got %0d expected 13", d_rd); end
        sel = 3'd0;
        tick();
        n_cmp++; if (d_rd !== 32'd14) begin n_err++; $display("FAIL mask_ch0: got %0d expected 14", d_rd); end
    endtask

    task automatic test_wrap_sat();
        do_reset();
        ev = 5'b00001;
        repeat (15) tick();
        ev   = 5'b0;
        sel  = 3'd0;
        live = 1'b1;
        tick();
        n_cmp++; if (w_rd !== 32'd15) begin n_err++; $display("FAIL wrap_at_max: got %0d expected 15", w_rd); end
        n_cmp++; if (s_rd !== 32'd15) begin n_err++; $display("FAIL sat_at_max: got %0d expected 15", s_rd); end
        n_cmp++; if (w_ovf !== 4'b0000) begin n_err++; $display("FAIL wrap_no_ovf: got %b expected 0000", w_ovf); end
        n_cmp++; if (s_ovf !== 5'b00000) begin n_err++; $display("FAIL sat_no_ovf: got %b expected 00000", s_ovf); end
        ev = 5'b00001;
        tick();
        ev = 5'b0;
        tick();
        n_cmp++; if (w_rd !== 32'd0) begin n_err++; $display("FAIL wrap_to_zero: got %0d expected 0", w_rd); end
        n_cmp++; if (w_ovf !== 4'b0001) begin n_err++; $display("FAIL wrap_ovf: got %b expected 0001", w_ovf); end
        n_cmp++; if (s_rd !== 32'd15) begin n_err++; $display("FAIL sat_hold: got %0d expected 15", s_rd); end
        n_cmp++; if (s_ovf !== 5'b00001) begin n_err++; $display("FAIL sat_ovf: got %b expected 00001", s_ovf); end
        ev = 5'b00001;
        tick();
        ev = 5'b0;
        tick();
        n_cmp++; if (w_rd !== 32'd1) begin n_err++; $display("FAIL wrap_17: got %0d expected 1", w_rd); end
        n_cmp++; if (s_rd !== 32'd15) begin n_err++; $display("FAIL sat_17: got %0d expected 15", s_rd); end
        n_cmp++; if (d_rd !== 32'd17) begin n_err++; $display("FAIL wide_17: got %0d expected 17", d_rd); end
        n_cmp++; if (w_ovf !== 4'b0001) begin n_err++; $display("FAIL wrap_ovf_sticky: got %b expected 0001", w_ovf); end
    endtask

    task automatic test_halt();
        do_reset();
        ev = 5'b00010;
        repeat (5) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_cmp++; if (d_run !== 1'b0) begin n_err++; $display("FAIL halt_running: got %0d expected 0", d_run); end
        repeat (20) tick();
        ev   = 5'b0;
        sel  = 3'd1;
        live = 1'b1;
        tick();
        n_cmp++; if (d_rd !== 32'd6) begin n_err++; $display("FAIL halt_ch1: got %0d expected 6", d_rd); end
        n_cmp++; if (d_run !== 1'b0) begin n_err++; $display("FAIL halt_stays: got %0d expected 0", d_run); end
        snap = 1'b1;
        live = 1'b0;
        tick();
        snap = 1'b0;
        tick();
        n_cmp++; if (d_rd !== 32'd6) begin n_err++; $display("FAIL halt_snap: got %0d expected 6", d_rd); end
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL halt_snap_valid: got %0d expected 1", d_valid); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (d_run !== 1'b1) begin n_err++; $display("FAIL clr_running: got %0d expected 1", d_run); end
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL clr_rd: got %0d expected 0", d_rd); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %0d expected 0", d_valid); end
        live = 1'b1;
        tick();
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL clr_ch1: got %0d expected 0", d_rd); end
        ev = 5'b00010;
        tick();
        ev = 5'b0;
        tick();
        n_cmp++; if (d_rd !== 32'd1) begin n_err++; $display("FAIL resume_ch1: got %0d expected 1", d_rd); end
    endtask

    task automatic test_clr_priority();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        ev   = 5'b00001;
        repeat (16) tick();
        ev = 5'b0;
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL pre_clr_valid: got %0d expected 1", d_valid); end
        n_cmp++; if (w_ovf !== 4'b0001) begin n_err++; $display("FAIL pre_clr_ovf: got %b expected 0001", w_ovf); end
        clr  = 1'b1;
        snap = 1'b1;
        halt = 1'b1;
        ev   = 5'b11111;
        tick();
        clr  = 1'b0;
        snap = 1'b0;
        halt = 1'b0;
        ev   = 5'b0;
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL clrprio_valid: got %0d expected 0", d_valid); end
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL clrprio_rd: got %0d expected 0", d_rd); end
        n_cmp++; if (d_run !== 1'b1) begin n_err++; $display("FAIL clrprio_running: got %0d expected 1", d_run); end
        n_cmp++; if (w_ovf !== 4'b0000) begin n_err++; $display("FAIL clrprio_ovf: got %b expected 0000", w_ovf); end
        live = 1'b0;
        sel  = 3'd1;
        tick();
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL clrprio_shadow: got %0d expected 0", d_rd); end
        live = 1'b1;
        sel  = 3'd0;
        tick();
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL clrprio_cnt: got %0d expected 0", d_rd); end
        n_cmp++; if (w_rd !== 32'd0) begin n_err++; $display("FAIL clrprio_cnt_wrap: got %0d expected 0", w_rd); end
    endtask

    task automatic test_sel_range();
        ev = 5'b11111;
        repeat (3) tick();
        ev   = 5'b0;
        live = 1'b1;
        sel  = 3'd4;
        tick();
        n_cmp++; if (s_rd !== 32'd3) begin n_err++; $display("FAIL sel4: got %0d expected 3", s_rd); end
        sel = 3'd5;
        tick();
        n_cmp++; if (s_rd !== 32'd0) begin n_err++; $display("FAIL sel5_oob: got %0d expected 0", s_rd); end
        sel = 3'd7;
        tick();
        n_cmp++; if (s_rd !== 32'd0) begin n_err++; $display("FAIL sel7_oob: got %0d expected 0", s_rd); end
    endtask

    task automatic test_reset_mid();
        ev = 5'b11111;
        repeat (20) tick();
        snap = 1'b1;
        sel  = 3'd3;
        tick();
        rst = 1'b0;
        tick();
        rst  = 1'b1;
        ev   = 5'b0;
        snap = 1'b0;
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL rstmid_rd: got %0d expected 0", d_rd); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0d expected 0", d_valid); end
        n_cmp++; if (w_ovf !== 4'b0000) begin n_err++; $display("FAIL rstmid_ovf_wrap: got %b expected 0000", w_ovf); end
        n_cmp++; if (s_ovf !== 5'b00000) begin n_err++; $display("FAIL rstmid_ovf_sat: got %b expected 00000", s_ovf); end
        n_cmp++; if (d_run !== 1'b1) begin n_err++; $display("FAIL rstmid_running: got %0d expected 1", d_run); end
        live = 1'b1;
        tick();
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d expected 0", d_rd); end
        live = 1'b0;
        tick();
        n_cmp++; if (d_rd !== 32'd0) begin n_err++; $display("FAIL rstmid_shadow: got %0d expected 0", d_rd); end
    endtask

    initial begin
        rst     = 1'b0;
        clr     = 1'b0;
        halt    = 1'b0;
        snap    = 1'b0;
        live    = 1'b0;
        ev      = 5'b0;
        en_mask = 5'b11111;
        sel     = 3'd0;
        test_reset();
        test_count_snap();
        test_wrap_sat();
        test_halt();
        test_clr_priority();
        test_sel_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
